// File: rtl/nx_capture_pkg.sv
// Shared types and width helpers for the mesh output delta-capture block.
package nx_capture_pkg;

  // Chunk index width: at least one bit, even for a single-chunk vector.
  function automatic int idx_w_f(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  // Total change-record width: {cycle, chunk index, chunk data}.
  function automatic int rec_w_f(input int cyc_w, input int idx_w, input int chunk_w);
    return cyc_w + idx_w + chunk_w;
  endfunction

  // Record layout for the default configuration (16-bit stamp, 8 chunks of 8 bits).
  localparam int DEF_CYC_W   = 16;
  localparam int DEF_IDX_W   = 3;
  localparam int DEF_CHUNK_W = 8;

  typedef struct packed {
    logic [DEF_CYC_W-1:0]   cycle;
    logic [DEF_IDX_W-1:0]   idx;
    logic [DEF_CHUNK_W-1:0] data;
  } capture_rec_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } cap_state_e;

endpackage

// File: rtl/nx_capture_fifo.sv
// Show-ahead record FIFO: head entry is always visible on pop_data_o.
// Push is gated by the registered full flag, pop by the registered empty flag.
module nx_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("nx_capture_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s  = push_i & ~full_q;
  assign do_pop_s   = pop_i & ~empty_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

  // Occupancy next-state from accepted push/pop.
  always_comb begin
    count_d = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage array; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == CNT_W'(0));
    end
  end

endmodule

// File: rtl/nx_output_capture.sv
// Snapshots the mesh boundary outputs on each tick, walks the snapshot one
// chunk per cycle against the last emitted values and streams a record for
// every chunk that differs (or every chunk when a full dump is requested).
module nx_output_capture
  import nx_capture_pkg::*;
#(
  parameter  int OUT_W      = 64,
  parameter  int CHUNK_W    = 8,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CYC_W      = 16,
  localparam int NCHUNK     = OUT_W / CHUNK_W,
  localparam int IDX_W      = idx_w_f(NCHUNK),
  localparam int REC_W      = rec_w_f(CYC_W, IDX_W, CHUNK_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [OUT_W-1:0] outputs_i,
  input  logic             full_dump,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic             busy,
  output logic [7:0]       overrun_count
);

  if ((OUT_W % CHUNK_W) != 0) begin : g_chunk_check
    $error("nx_output_capture: OUT_W must be a multiple of CHUNK_W");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  cap_state_e         state_q, state_d;
  logic [OUT_W-1:0]   snap_q, snap_d;
  logic [OUT_W-1:0]   prev_q, prev_d;
  logic [CYC_W-1:0]   cap_cyc_q, cap_cyc_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               dump_now_q, dump_now_d;
  logic               dump_pending_q, dump_pending_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [7:0]         ovr_q, ovr_d;

  logic [CHUNK_W-1:0] snap_chunk_s;
  logic [CHUNK_W-1:0] prev_chunk_s;
  logic               emit_s;
  logic               advance_s;
  logic               push_s;
  logic [REC_W-1:0]   push_rec_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  assign snap_chunk_s  = snap_q[int'(scan_idx_q) * CHUNK_W +: CHUNK_W];
  assign prev_chunk_s  = prev_q[int'(scan_idx_q) * CHUNK_W +: CHUNK_W];
  assign emit_s        = (snap_chunk_s != prev_chunk_s) | dump_now_q;
  assign push_rec_s    = {cap_cyc_q, scan_idx_q, snap_chunk_s};

  assign rec_valid     = ~fifo_empty_s;
  assign busy          = (state_q == SCAN) | rec_valid;
  assign overrun_count = ovr_q;

  // Capture/scan FSM next-state: accept ticks in IDLE, walk chunks in SCAN.
  always_comb begin
    state_d        = state_q;
    snap_d         = snap_q;
    prev_d         = prev_q;
    cap_cyc_d      = cap_cyc_q;
    cyc_d          = cyc_q;
    dump_now_d     = dump_now_q;
    dump_pending_d = dump_pending_q;
    scan_idx_d     = scan_idx_q;
    ovr_d          = ovr_q;
    push_s         = 1'b0;
    advance_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d     = outputs_i;
          cap_cyc_d  = cyc_q;
          cyc_d      = cyc_q + CYC_W'(1);
          dump_now_d = dump_pending_q | full_dump;
          scan_idx_d = '0;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // A tick here is dropped, but the stamp counter keeps real time.
        if (tick) begin
          cyc_d = cyc_q + CYC_W'(1);
          if (ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
          end else begin
            ovr_d = ovr_q;
          end
        end else begin
          ovr_d = ovr_q;
        end

        // A changed chunk waits for FIFO space; unchanged chunks are skipped.
        if (emit_s) begin
          if (!fifo_full_s) begin
            push_s = 1'b1;
            prev_d[int'(scan_idx_q) * CHUNK_W +: CHUNK_W] = snap_chunk_s;
            advance_s = 1'b1;
          end else begin
            advance_s = 1'b0;
          end
        end else begin
          advance_s = 1'b1;
        end

        if (advance_s) begin
          if (scan_idx_q == LAST_IDX) begin
            state_d        = IDLE;
            dump_pending_d = 1'b0;
            dump_now_d     = 1'b0;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end else begin
          scan_idx_d = scan_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A dump request is remembered in any state; raised late it covers the next capture.
    if (full_dump) begin
      dump_pending_d = 1'b1;
    end else begin
      dump_pending_d = dump_pending_d;
    end
  end

  // FSM, snapshot, last-emitted and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snap_q         <= '0;
      prev_q         <= '0;
      cap_cyc_q      <= '0;
      cyc_q          <= '0;
      dump_now_q     <= 1'b0;
      dump_pending_q <= 1'b0;
      scan_idx_q     <= '0;
      ovr_q          <= 8'd0;
    end else begin
      state_q        <= state_d;
      snap_q         <= snap_d;
      prev_q         <= prev_d;
      cap_cyc_q      <= cap_cyc_d;
      cyc_q          <= cyc_d;
      dump_now_q     <= dump_now_d;
      dump_pending_q <= dump_pending_d;
      scan_idx_q     <= scan_idx_d;
      ovr_q          <= ovr_d;
    end
  end

  nx_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_rec_s),
    .pop_i       (rec_valid & rec_ready),
    .pop_data_o  (rec_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

endmodule

// File: doc/nx_output_capture.md
Name: nx_output_capture

Overview:
- Sits directly downstream of the mesh boundary outputs.
- Takes a snapshot of the flattened boundary output vector on each simulated-cycle `tick`.
- Compares the snapshot chunk-by-chunk against the last values it emitted.
- Streams one change record per differing chunk to the host link over a valid/ready interface, so the host only receives deltas.

Parameters:
- OUT_W, 64: width of the flattened mesh boundary output vector.
- CHUNK_W, 8: bits per compared and emitted chunk. OUT_W % CHUNK_W must equal 0 (elaboration error otherwise).
- FIFO_DEPTH, 8: record FIFO entries. Must be a power of 2, ≥2.
- CYC_W, 16: width of the simulated-cycle stamp. Wraps modulo 2^CYC_W.
- Derived: NCHUNK = OUT_W/CHUNK_W; IDX_W = max(1, clog2(NCHUNK)); REC_W = CYC_W+IDX_W+CHUNK_W.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- tick, in, 1: single-cycle pulse marking the end of one simulated mesh cycle.
- outputs_i, in, OUT_W: mesh boundary outputs. Stable in the cycle `tick` is high.
- full_dump, in, 1: pulse requesting that every chunk be emitted on the next capture.
- rec_valid, out, 1: record available.
- rec_ready, in, 1: consumer accepts the record.
- rec_data, out, REC_W: {cycle[CYC_W-1:0], chunk_idx[IDX_W-1:0], chunk_data[CHUNK_W-1:0]}, MSB first.
- busy, out, 1: scan in progress or FIFO non-empty.
- overrun_count, out, 8: saturating count of ticks dropped while scanning.

Behaviour:
- Reset values (async on rst): prev snapshot = 0, cycle counter = 0, FIFO empty, rec_valid = 0, rec_data = 0, busy = 0, overrun_count = 0, dump_pending = 0, FSM = IDLE.
- FSM has two states, IDLE and SCAN.
- IDLE, tick = 1 at clock edge:
  - snap <= outputs_i.
  - cap_cyc <= cycle counter; cycle counter increments, wrapping.
  - dump_now <= dump_pending | full_dump.
  - scan_idx <= 0; go to SCAN.
- SCAN, one chunk examined per cycle at scan_idx:
  - Emit condition: snap chunk != prev chunk, or dump_now.
  - Emit and FIFO not full: push {cap_cyc, scan_idx, snap chunk}; prev chunk <= snap chunk; advance.
  - Emit and FIFO full: stall. scan_idx, snap and prev hold.
  - No emit: advance without pushing.
  - Advance from scan_idx = NCHUNK-1: go to IDLE, clear dump_pending and dump_now.
- Scan length: exactly NCHUNK cycles with no stalls.
- tick while in SCAN:
  - The capture is dropped and snap is unchanged.
  - overrun_count increments, saturating at 255.
  - The cycle counter still increments, so stamps track real mesh cycles.
- full_dump:
  - Sets dump_pending in any state.
  - If asserted in the same cycle as a tick accepted in IDLE, it applies to that capture.
  - If asserted during SCAN, it applies to the next capture.
- FIFO is show-ahead. rec_valid = !empty; rec_data = head entry.
  - Pop when rec_valid & rec_ready.
  - Simultaneous push and pop when full: the pop frees space, but the push is still gated by the registered full flag and is not taken that cycle.
  - Simultaneous push and pop when empty: the new entry appears the following cycle.
- Latency:
  - Tick high in cycle 0 → chunk 0 record valid in cycle 2, with rec_ready held high and chunk 0 changed.
  - Chunk k appears no earlier than cycle 2+k.
- busy = (state == SCAN) | rec_valid.
- Reset mid-scan or with FIFO non-empty: all state is discarded immediately; no partial records survive.

Decomposition:
- Package nx_capture_pkg holds:
  - the REC_W derivation helpers;
  - a packed struct `capture_rec_t` {cycle, idx, data};
  - the FSM state enum {IDLE, SCAN}.
- Sub-module nx_capture_fifo: parameterised synchronous show-ahead FIFO (WIDTH, DEPTH) with full/empty flags and the same async rst.
- FSM, snapshot/prev registers and counters live in nx_output_capture.

Test Plan:
- Reset, rec_ready = 1, outputs_i = 0, one tick → no record ever asserts; busy high for exactly 8 cycles then low; cycle counter = 1.
- Second tick with outputs_i = 64'h0000_0000_00A5_0000 → exactly one record, rec_data = {16'd1, 3'd2, 8'hA5}, valid in cycle 2+2 after the tick.
- full_dump pulsed with the tick, outputs_i = 64'h0123_4567_89AB_CDEF → 8 records, idx 0..7, data EF, CD, AB, 89, 67, 45, 23, 01; an immediately following tick with the same data → zero records.
- rec_ready = 0, all chunks changed, FIFO_DEPTH = 4 → 4 records queued; scan stalls at idx 4 with busy = 1; release rec_ready → remaining 4 emitted in order, no loss or duplication.
- Tick pulsed 3 cycles after a tick that starts a full scan → overrun_count = 1; the dropped tick emits no record; the next accepted capture is stamped with cycle counter value 2.
- CYC_W = 4, 17 ticks with a changing chunk each time → the stamp wraps from 15 to 0; rst asserted mid-scan → rec_valid = 0 and overrun_count = 0 immediately, and the next tick is stamped 0.
